// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the byte-serial instruction fetch path.
package inst_fetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam int BPI = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   // Clears the low 'lsb' bits so a redirect lands on an instruction boundary.
   function automatic logic [63:0] align_pc(input logic [63:0] pc, input int unsigned lsb);
      return pc & ~((64'd1 << lsb) - 64'd1);
   endfunction

endpackage

// File: rtl/inst_byte_assembler.sv
// Slot buffer collecting one byte per cycle; word_o is big-endian (slot 0 in the MSBs)
// and already includes the byte being written this cycle, so the last byte needs no extra cycle.
module inst_byte_assembler #(
   parameter int WORD  = 8,
   parameter int NSLOT = 4,
   parameter int SW    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  wr_en_i,
   input  logic [SW-1:0]         wr_idx_i,
   input  logic [WORD-1:0]       wr_dat_i,
   output logic [NSLOT*WORD-1:0] word_o
);

   logic [WORD-1:0] buf_q [NSLOT];

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         for (int i = 0; i < NSLOT; i++) buf_q[i] <= '0;
      end else if (wr_en_i) begin
         buf_q[wr_idx_i] <= wr_dat_i;
      end
   end

   always_comb begin
      word_o = '0;
      for (int i = 0; i < NSLOT; i++) begin
         word_o[(NSLOT-i)*WORD-1 -: WORD] =
            (wr_en_i && (wr_idx_i == SW'(i))) ? wr_dat_i : buf_q[i];
      end
   end

endmodule

// File: rtl/inst_fetch_assembler.sv
// Byte-serial instruction fetch: walks mem_addr over BPI bytes, presents the assembled
// instruction with valid/ready, and restarts on redirect (which beats everything except rst).
module inst_fetch_assembler
   import inst_fetch_pkg::*;
#(
   parameter int             WORD     = 8,
   parameter int             PCL      = 32,
   parameter int             INSTW    = 32,
   parameter logic [PCL-1:0] RESET_PC = PCL'(DEF_RESET_PC)
) (
   input  logic             clk,
   input  logic             rst,
   output logic [PCL-1:0]   mem_addr,
   input  logic [WORD-1:0]  mem_data,
   input  logic             redirect,
   input  logic [PCL-1:0]   redirect_pc,
   input  logic             inst_ready,
   output logic             inst_valid,
   output logic [INSTW-1:0] inst,
   output logic [PCL-1:0]   inst_pc
);

   localparam int NB = INSTW / WORD;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [PCL-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PCL-1:0]   inst_pc_q, inst_pc_d;
   logic [INSTW-1:0] inst_q, inst_d;
   logic             valid_q, valid_d;
   logic             asm_wr, asm_clr;
   logic [INSTW-1:0] asm_word;
   logic [PCL-1:0]   redir_tgt;

   assign redir_tgt = PCL'(align_pc(64'(redirect_pc), CW));

   // HOLD always has byte_cnt_q == 0, but the select keeps the intent explicit.
   assign mem_addr = (state_q == HOLD) ? fetch_pc_q : fetch_pc_q + PCL'(byte_cnt_q);

   inst_byte_assembler #(
      .WORD  (WORD),
      .NSLOT (NB),
      .SW    (CW)
   ) u_asm (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (asm_clr),
      .wr_en_i  (asm_wr),
      .wr_idx_i (byte_cnt_q),
      .wr_dat_i (mem_data),
      .word_o   (asm_word)
   );

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      fetch_pc_d = fetch_pc_q;
      inst_pc_d  = inst_pc_q;
      inst_d     = inst_q;
      valid_d    = valid_q;
      asm_wr     = 1'b0;
      asm_clr    = 1'b0;
      if (redirect) begin
         fetch_pc_d = redir_tgt;
         byte_cnt_d = '0;
         state_d    = FETCH;
         valid_d    = 1'b0;
         asm_clr    = 1'b1;
      end else begin
         case (state_q)
            FETCH: begin
               asm_wr = 1'b1;
               if (byte_cnt_q == CW'(NB-1)) begin
                  inst_d     = asm_word;
                  inst_pc_d  = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + PCL'(NB);
                  byte_cnt_d = '0;
                  valid_d    = 1'b1;
                  state_d    = HOLD;
               end else begin
                  byte_cnt_d = byte_cnt_q + CW'(1);
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  valid_d = 1'b0;
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         byte_cnt_q <= '0;
         fetch_pc_q <= RESET_PC;
         inst_pc_q  <= '0;
         inst_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         fetch_pc_q <= fetch_pc_d;
         inst_pc_q  <= inst_pc_d;
         inst_q     <= inst_d;
         valid_q    <= valid_d;
      end
   end

   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch_assembler.sv
// Bench for inst_fetch_assembler: directed table, corner sequences, and a random run
// against a transaction-level reference (instruction PC plus fetch countdown).
module tb_inst_fetch_assembler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, redirect, inst_ready, inst_valid;
   logic [31:0] redirect_pc, mem_addr, inst, inst_pc;
   logic [7:0]  mem_data;

   logic        rst_w, redirect_w, ready_w, inst_valid_w;
   logic [31:0] redirect_pc_w, mem_addr_w, inst_w, inst_pc_w;
   logic [7:0]  mem_data_w;

   logic [7:0]  mem [256];

   assign mem_data   = (mem_addr   < 32'd256) ? mem[mem_addr[7:0]]   : 8'h40;
   assign mem_data_w = (mem_addr_w < 32'd256) ? mem[mem_addr_w[7:0]] : 8'h40;

   inst_fetch_assembler dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .inst_ready(inst_ready),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
   );

   inst_fetch_assembler #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst_w), .mem_addr(mem_addr_w), .mem_data(mem_data_w),
      .redirect(redirect_w), .redirect_pc(redirect_pc_w), .inst_ready(ready_w),
      .inst_valid(inst_valid_w), .inst(inst_w), .inst_pc(inst_pc_w)
   );

   int errors = 0;
   int checks = 0;

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      return (a < 32'd256) ? mem[a[7:0]] : 8'h40;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic av, input logic [31:0] ai, input logic [31:0] ap, input logic [31:0] aa,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ea);
      checks++;
      if (av !== ev || ai !== ei || ap !== ep || aa !== ea) begin
         errors++;
         $display("FAIL %s: got valid=%0b inst=%h pc=%h addr=%h, expected valid=%0b inst=%h pc=%h addr=%h",
                  name, av, ai, ap, aa, ev, ei, ep, ea);
      end
   endtask

   task automatic chk_d(input string name, input logic ev, input logic [31:0] ei,
                        input logic [31:0] ep, input logic [31:0] ea);
      chk(name, inst_valid, inst, inst_pc, mem_addr, ev, ei, ep, ea);
   endtask

   task automatic chk_w(input string name, input logic ev, input logic [31:0] ei,
                        input logic [31:0] ep, input logic [31:0] ea);
      chk(name, inst_valid_w, inst_w, inst_pc_w, mem_addr_w, ev, ei, ep, ea);
   endtask

   task automatic chk_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: the instruction currently being fetched or held, and how many fetch cycles remain.
   logic        m_vld;
   logic [31:0] m_pc, m_inst, m_ipc;
   int          m_wait;

   task automatic mdl_reset();
      m_vld  = 1'b0;
      m_pc   = 32'h0;
      m_wait = 4;
      m_inst = 32'h0;
      m_ipc  = 32'h0;
   endtask

   task automatic mdl_edge(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
      if (r) begin
         mdl_reset();
      end else if (rd) begin
         m_vld  = 1'b0;
         m_pc   = rp & ~32'd3;
         m_wait = 4;
      end else if (m_vld) begin
         if (rdy) begin
            m_vld  = 1'b0;
            m_pc   = m_pc + 32'd4;
            m_wait = 4;
         end
      end else begin
         m_wait--;
         if (m_wait == 0) begin
            m_vld  = 1'b1;
            m_ipc  = m_pc;
            m_inst = {mem_rd(m_pc), mem_rd(m_pc + 32'd1), mem_rd(m_pc + 32'd2), mem_rd(m_pc + 32'd3)};
         end
      end
   endtask

   function automatic logic [31:0] mdl_addr();
      return m_vld ? m_pc + 32'd4 : m_pc + 32'(4 - m_wait);
   endfunction

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep;
      logic [31:0] ea;
   } vec_t;

   vec_t tv [21];

   initial begin
      int nvld;
      int hs;
      logic r, rd, rdy;
      logic [31:0] rp;

      for (int i = 0; i < 256; i++) mem[i] = 8'h40;
      {mem[0], mem[1], mem[2],  mem[3]}  = 32'h8C01_0004;
      {mem[4], mem[5], mem[6],  mem[7]}  = 32'hAC02_0008;
      {mem[8], mem[9], mem[10], mem[11]} = 32'h1122_3344;
      {mem[16], mem[17], mem[18], mem[19]} = 32'hDEAD_BEEF;
      {mem[32], mem[33], mem[34], mem[35]} = 32'hCAFE_BABE;

      tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0, 32'h0};
      tv[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0, 32'h1};
      tv[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0, 32'h2};
      tv[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0, 32'h3};
      tv[4]  = '{1'b0, 1'b1, 1'b1, 32'h8C01_0004, 32'h0, 32'h4};
      tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h8C01_0004, 32'h0, 32'h4};
      tv[6]  = '{1'b0, 1'b1, 1'b0, 32'h8C01_0004, 32'h0, 32'h5};
      tv[7]  = '{1'b0, 1'b1, 1'b0, 32'h8C01_0004, 32'h0, 32'h6};
      tv[8]  = '{1'b0, 1'b1, 1'b0, 32'h8C01_0004, 32'h0, 32'h7};
      tv[9]  = '{1'b0, 1'b0, 1'b1, 32'hAC02_0008, 32'h4, 32'h8};
      for (int i = 10; i < 16; i++) tv[i] = '{1'b0, 1'b0, 1'b1, 32'hAC02_0008, 32'h4, 32'h8};
      tv[16] = '{1'b0, 1'b1, 1'b0, 32'hAC02_0008, 32'h4, 32'h8};
      tv[17] = '{1'b0, 1'b1, 1'b0, 32'hAC02_0008, 32'h4, 32'h9};
      tv[18] = '{1'b0, 1'b1, 1'b0, 32'hAC02_0008, 32'h4, 32'hA};
      tv[19] = '{1'b0, 1'b1, 1'b0, 32'hAC02_0008, 32'h4, 32'hB};
      tv[20] = '{1'b0, 1'b1, 1'b1, 32'h1122_3344, 32'h8, 32'hC};

      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
      rst_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = 32'h0; ready_w = 1'b1;

      // Wrap-around instance: fetch from the top of the address space into 0.
      step();
      chk_w("wrap_reset", 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
      rst_w = 1'b0;
      for (int k = 1; k < 4; k++) begin
         step();
         chk_w($sformatf("wrap_addr%0d", k), 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC + 32'(k));
      end
      step();
      chk_w("wrap_first", 1'b1, 32'h4040_4040, 32'hFFFF_FFFC, 32'h0);
      step();
      chk_w("wrap_fetch0", 1'b0, 32'h4040_4040, 32'hFFFF_FFFC, 32'h0);
      repeat (3) step();
      step();
      chk_w("wrap_second", 1'b1, 32'h8C01_0004, 32'h0, 32'h4);

      for (int i = 0; i < 21; i++) begin
         rst = tv[i].rst;
         inst_ready = tv[i].rdy;
         step();
         chk_d($sformatf("vec%0d", i), tv[i].ev, tv[i].ei, tv[i].ep, tv[i].ea);
      end

      // Redirect two bytes into an assembly.
      rst = 1'b1; step(); rst = 1'b0; inst_ready = 1'b1;
      step(); step();
      chk_d("mid_cnt2", 1'b0, 32'h0, 32'h0, 32'h2);
      redirect = 1'b1; redirect_pc = 32'h13;
      step();
      chk_d("mid_redir", 1'b0, 32'h0, 32'h0, 32'h10);
      redirect = 1'b0;
      nvld = 0;
      repeat (3) begin step(); if (inst_valid) nvld++; end
      chk_val("mid_no_early_valid", nvld, 0);
      step();
      chk_d("mid_inst", 1'b1, 32'hDEAD_BEEF, 32'h10, 32'h14);

      // Redirect and handshake in the same HOLD cycle.
      inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h22;
      hs = (inst_valid && inst_ready) ? 1 : 0;
      step();
      chk_d("hold_redir", 1'b0, 32'hDEAD_BEEF, 32'h10, 32'h20);
      redirect = 1'b0;
      nvld = 0;
      repeat (3) begin
         if (inst_valid && inst_ready) hs++;
         step();
         if (inst_valid) nvld++;
      end
      if (inst_valid && inst_ready) hs++;
      inst_ready = 1'b0;
      step();
      chk_val("hold_redir_stale", nvld, 0);
      chk_val("hold_redir_handshakes", hs, 1);
      chk_d("hold_redir_inst", 1'b1, 32'hCAFE_BABE, 32'h20, 32'h24);

      // Reset while holding a valid instruction, then fetch unprogrammed memory.
      rst = 1'b1;
      step();
      chk_d("rst_in_hold", 1'b0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h201;
      step();
      redirect = 1'b0;
      repeat (4) step();
      chk_d("unprogrammed", 1'b1, 32'h4040_4040, 32'h200, 32'h204);

      // Random traffic against the reference.
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      rst = 1'b1; redirect = 1'b0; inst_ready = 1'b0;
      step();
      mdl_reset();
      for (int c = 0; c < 800; c++) begin
         r   = ($urandom_range(0, 63) == 0);
         rd  = ($urandom_range(0, 15) == 0);
         rp  = $urandom_range(0, 1) ? 32'($urandom_range(0, 255)) : $urandom;
         rdy = 1'($urandom_range(0, 1));
         rst = r; redirect = rd; redirect_pc = rp; inst_ready = rdy;
         mdl_edge(r, rd, rp, rdy);
         step();
         chk_d($sformatf("rand%0d", c), m_vld, m_inst, m_ipc, mdl_addr());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
